// File: rtl/display_counter_3bits.sv
// Button-driven 3-bit up/down counter with synchronizers, debounce and auto-repeat.
// The registered digit feeds the display_3bits 7-segment decoder.
module display_counter_3bits #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_clear,
  output logic [2:0] digit,
  output logic       step_pulse,
  output logic       wrap_pulse
);

  localparam int DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]  RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]  RP_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    REPEAT
  } state_t;

  // Button index 0 = up, 1 = down, 2 = clear.
  logic [2:0]     raw;
  logic [2:0]     sync1;
  logic [2:0]     sync2;
  logic [2:0]     deb;
  logic [2:0]     deb_q;
  logic [2:0]     press;
  logic [DBW-1:0] db_cnt [3];

  state_t        state;
  state_t        state_n;
  logic          dir_up;
  logic          dir_n;
  logic [RW-1:0] rpt_cnt;
  logic [RW-1:0] cnt_n;
  logic          do_step;
  logic          step_up;
  logic          held;
  logic [2:0]    digit_n;
  logic          wrap_n;

  assign raw   = {btn_clear, btn_down, btn_up};
  assign press = deb & ~deb_q;

  // A differing sample must persist DEBOUNCE_CYCLES cycles; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // The FSM tracks only the button that started the press; clear overrides everything.
  always_comb begin
    state_n = state;
    dir_n   = dir_up;
    cnt_n   = rpt_cnt;
    do_step = 1'b0;
    step_up = dir_up;
    held    = dir_up ? deb[0] : deb[1];
    if (press[2]) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (press[0] && !press[1]) begin
            do_step = 1'b1;
            step_up = 1'b1;
            dir_n   = 1'b1;
            state_n = PRESS;
            cnt_n   = '0;
          end else if (press[1] && !press[0]) begin
            do_step = 1'b1;
            step_up = 1'b0;
            dir_n   = 1'b0;
            state_n = PRESS;
            cnt_n   = '0;
          end
        end
        PRESS: begin
          if (!held) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (rpt_cnt == RD_LAST) begin
            do_step = 1'b1;
            state_n = REPEAT;
            cnt_n   = '0;
          end else begin
            cnt_n = rpt_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!held) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (rpt_cnt == RP_LAST) begin
            do_step = 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n = rpt_cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end

    digit_n = digit;
    wrap_n  = 1'b0;
    if (press[2]) begin
      digit_n = 3'd0;
    end else if (do_step) begin
      digit_n = step_up ? digit + 3'd1 : digit - 3'd1;
      wrap_n  = step_up ? (digit == 3'd7) : (digit == 3'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dir_up     <= 1'b0;
      rpt_cnt    <= '0;
      digit      <= 3'd0;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      dir_up     <= dir_n;
      rpt_cnt    <= cnt_n;
      digit      <= digit_n;
      step_pulse <= do_step;
      wrap_pulse <= wrap_n;
    end
  end

endmodule

// File: tb/tb_display_counter_3bits.sv
// Scoreboard bench for display_counter_3bits: predicted steps (edge, digit, wrap) are
// queued when a button is driven and matched against every step_pulse.
module tb_display_counter_3bits;

  localparam int DB = 4;
  localparam int RD = 16;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_clear = 1'b0;
  logic [2:0] digit;
  logic       step_pulse;
  logic       wrap_pulse;

  typedef struct {
    int         edge_no;
    logic [2:0] d;
    logic       w;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [2:0] model_digit = 3'd0;

  display_counter_3bits #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_clear (btn_clear),
    .digit     (digit),
    .step_pulse(step_pulse),
    .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Button raised before edge k and dropped before edge k+h: first step at k+DB+2,
  // then after RD cycles, then every RP cycles, as long as release has not debounced.
  task automatic push_expected(input bit up, input int k, input int h, input int stop_edge);
    int   t;
    int   last;
    exp_t e;
    t    = k + DB + 2;
    last = k + h + DB + 1;
    while (t <= last && t <= stop_edge) begin
      e.edge_no   = t;
      e.w         = up ? (model_digit == 3'd7) : (model_digit == 3'd0);
      model_digit = up ? model_digit + 3'd1 : model_digit - 3'd1;
      e.d         = model_digit;
      sb.push_back(e);
      t = t + ((t == k + DB + 2) ? RD : RP);
    end
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0:       btn_up = v;
      1:       btn_down = v;
      default: btn_clear = v;
    endcase
  endtask

  task automatic settle_and_check(input string tag);
    repeat (30) @(negedge clk);
    checkOutput({tag, "_drain"}, sb.size(), 0);
    checkOutput({tag, "_digit"}, digit, model_digit);
  endtask

  task automatic applyStimulus(input int idx, input int bounce, input int h, input string tag);
    int k;
    @(negedge clk);
    for (int i = 0; i < bounce; i++) begin
      set_btn(idx, (i % 2) == 0);
      @(negedge clk);
    end
    k = cyc + 1;
    set_btn(idx, 1'b1);
    if (idx < 2) push_expected(idx == 0, k, h, 1 << 30);
    else model_digit = 3'd0;
    repeat (h) @(negedge clk);
    set_btn(idx, 1'b0);
    settle_and_check(tag);
  endtask

  task automatic apply_pair(input int a, input int b, input string tag);
    @(negedge clk);
    set_btn(a, 1'b1);
    set_btn(b, 1'b1);
    if (a == 2 || b == 2) model_digit = 3'd0;
    repeat (12) @(negedge clk);
    set_btn(a, 1'b0);
    set_btn(b, 1'b0);
    settle_and_check(tag);
  endtask

  // Every step_pulse must match the oldest prediction in edge, digit and wrap.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (step_pulse) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_step", step_pulse, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("step_edge", cyc, e.edge_no);
          checkOutput("step_digit", digit, e.d);
          checkOutput("step_wrap", wrap_pulse, e.w);
        end
      end else if (wrap_pulse) begin
        checkOutput("wrap_without_step", wrap_pulse, 0);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    checkOutput("reset_digit", digit, 0);
    checkOutput("reset_step", step_pulse, 0);
    checkOutput("reset_wrap", wrap_pulse, 0);
    rst_n = 1'b1;

    applyStimulus(0, 0, 12, "single_up");
    applyStimulus(0, 6, 12, "bounce_up");

    @(negedge clk);
    btn_up = 1'b1;
    repeat (3) @(negedge clk);
    btn_up = 1'b0;
    settle_and_check("glitch");

    applyStimulus(2, 0, 12, "clear");
    applyStimulus(1, 0, 12, "wrap_down");
    applyStimulus(0, 0, 12, "wrap_up");
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 12, "count_to_5");
    applyStimulus(1, 0, 60, "repeat_down");

    apply_pair(0, 2, "up_clear");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 12, "count_to_3");
    apply_pair(0, 1, "up_down");

    // Async reset while auto-repeating, asserted mid-cycle.
    @(negedge clk);
    k = cyc + 1;
    btn_up = 1'b1;
    push_expected(1'b1, k, 1000, k + 33);
    repeat (34) @(negedge clk);
    #2;
    rst_n  = 1'b0;
    btn_up = 1'b0;
    #1;
    checkOutput("midreset_digit", digit, 0);
    checkOutput("midreset_step", step_pulse, 0);
    checkOutput("midreset_wrap", wrap_pulse, 0);
    checkOutput("midreset_drain", sb.size(), 0);
    model_digit = 3'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    settle_and_check("after_reset");

    // A button held across reset release is a fresh press.
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    btn_down = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k = cyc + 1;
    push_expected(1'b0, k, 12, 1 << 30);
    repeat (12) @(negedge clk);
    btn_down = 1'b0;
    settle_and_check("held_through_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
